// File: rtl/ariane_pkg.sv
// Shared core types for the branch-history update path: the predictor update
// record, the resolve bundle and the default update-queue depth.
package ariane_pkg;

    localparam int unsigned BHT_UPD_QUEUE_DEPTH = 4;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic        taken;
    } bht_update_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] pc;
        logic        taken;
        logic        is_cond;
    } bht_resolve_t;

endpackage

// File: rtl/bht_update_queue_if.sv
// Port bundle between the branch unit / controller side and the BHT update queue.
interface bht_update_queue_if
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH      = BHT_UPD_QUEUE_DEPTH,
    parameter int unsigned DROP_CNT_W = 16
);
    logic                         flush_i;
    logic                         debug_mode_i;
    logic                         resolve_valid_i;
    logic [63:0]                  resolve_pc_i;
    logic                         resolve_taken_i;
    logic                         resolve_is_cond_i;
    logic                         update_ready_i;
    bht_update_t                  bht_update_o;
    logic [$clog2(DEPTH+1)-1:0]   count_o;
    logic                         full_o;
    logic [DROP_CNT_W-1:0]        drop_cnt_o;

    modport master (
        output flush_i, debug_mode_i, resolve_valid_i, resolve_pc_i,
               resolve_taken_i, resolve_is_cond_i, update_ready_i,
        input  bht_update_o, count_o, full_o, drop_cnt_o
    );

    modport slave (
        input  flush_i, debug_mode_i, resolve_valid_i, resolve_pc_i,
               resolve_taken_i, resolve_is_cond_i, update_ready_i,
        output bht_update_o, count_o, full_o, drop_cnt_o
    );
endinterface

// File: rtl/bht_update_queue.sv
// FIFO of resolved conditional-branch outcomes draining one update per cycle
// into the predictor. Optional macro BHT_UPD_COALESCE_EN merges same-PC pushes.
module bht_update_queue
    import ariane_pkg::*;
#(
    parameter int unsigned DEPTH      = BHT_UPD_QUEUE_DEPTH,
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    bht_update_queue_if.slave bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [63:0]           pc_mem_r [DEPTH];
    logic [DEPTH-1:0]      taken_mem_r;
    logic [PTR_W-1:0]      head_r;
    logic [PTR_W-1:0]      tail_r;
    logic [CNT_W-1:0]      count_r;
    logic [DROP_CNT_W-1:0] drop_cnt_r;

    logic                  empty_s;
    logic                  full_s;
    logic                  push_req_s;
    logic                  pop_s;
    logic                  coalesce_s;
    logic                  alloc_s;
    logic                  drop_s;
    logic [PTR_W-1:0]      wr_ptr_s;
    bht_update_t           upd_s;

    assign empty_s    = (count_r == {CNT_W{1'b0}});
    assign full_s     = (count_r == CNT_W'(DEPTH));
    assign push_req_s = bus.resolve_valid_i & bus.resolve_is_cond_i & ~bus.debug_mode_i;
    assign pop_s      = ~empty_s & ~bus.debug_mode_i & bus.update_ready_i;

`ifdef BHT_UPD_COALESCE_EN
    logic [PTR_W-1:0]      last_ptr_s;
    assign last_ptr_s = tail_r - 1'b1;
    // The youngest entry may only be rewritten if it is not leaving this cycle.
    assign coalesce_s = push_req_s & ~empty_s
                      & (pc_mem_r[last_ptr_s] == bus.resolve_pc_i)
                      & ~(pop_s & (head_r == last_ptr_s));
    assign wr_ptr_s   = coalesce_s ? last_ptr_s : tail_r;
`else
    assign coalesce_s = 1'b0;
    assign wr_ptr_s   = tail_r;
`endif

    assign alloc_s = push_req_s & ~coalesce_s & (~full_s | pop_s);
    assign drop_s  = push_req_s & ~coalesce_s & full_s & ~pop_s;

    // Pointer, occupancy and drop-counter state; flush keeps the drop count.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_r     <= {PTR_W{1'b0}};
            tail_r     <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
            drop_cnt_r <= {DROP_CNT_W{1'b0}};
        end else if (bus.flush_i) begin
            head_r  <= {PTR_W{1'b0}};
            tail_r  <= {PTR_W{1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else begin
            if (pop_s) begin
                head_r <= head_r + 1'b1;
            end
            if (alloc_s) begin
                tail_r <= tail_r + 1'b1;
            end
            if (alloc_s && !pop_s) begin
                count_r <= count_r + 1'b1;
            end else if (!alloc_s && pop_s) begin
                count_r <= count_r - 1'b1;
            end
            if (drop_s && (drop_cnt_r != {DROP_CNT_W{1'b1}})) begin
                drop_cnt_r <= drop_cnt_r + 1'b1;
            end
        end
    end

    // Entry storage; contents are don't-care while unoccupied, so no reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !bus.flush_i) begin
            if (alloc_s) begin
                pc_mem_r[tail_r] <= bus.resolve_pc_i;
            end
            if (alloc_s || coalesce_s) begin
                taken_mem_r[wr_ptr_s] <= bus.resolve_taken_i;
            end
        end
    end

    // Head entry presented from storage only; zeroed while empty.
    always_comb begin
        upd_s = '0;
        if (!empty_s) begin
            upd_s.valid = ~bus.debug_mode_i;
            upd_s.pc    = pc_mem_r[head_r];
            upd_s.taken = taken_mem_r[head_r];
        end else begin
            upd_s = '0;
        end
    end

    assign bus.bht_update_o = upd_s;
    assign bus.count_o      = count_r;
    assign bus.full_o       = full_s;
    assign bus.drop_cnt_o   = drop_cnt_r;

endmodule

// File: tb/tb_bht_update_queue.sv
// Directed plus randomized bench for bht_update_queue, checked against a
// queue-based reference model of the update FIFO.
module tb_bht_update_queue;
    import ariane_pkg::*;

    localparam int unsigned DEPTH      = 4;
    localparam int unsigned DROP_CNT_W = 4;
    localparam int          DROP_MAX   = (1 << DROP_CNT_W) - 1;

    typedef struct {
        logic [63:0] pc;
        logic        taken;
    } ent_t;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    ent_t mq[$];
    int   m_drop = 0;

    bht_update_queue_if #(.DEPTH(DEPTH), .DROP_CNT_W(DROP_CNT_W)) bus ();

    bht_update_queue #(.DEPTH(DEPTH), .DROP_CNT_W(DROP_CNT_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input logic dbg);
        logic        e_valid;
        logic [63:0] e_pc;
        logic        e_taken;
        e_valid = (mq.size() > 0) && !dbg;
        e_pc    = (mq.size() > 0) ? mq[0].pc : 64'h0;
        e_taken = (mq.size() > 0) ? mq[0].taken : 1'b0;
        chk("valid", {63'h0, bus.bht_update_o.valid}, {63'h0, e_valid});
        chk("pc", bus.bht_update_o.pc, e_pc);
        chk("taken", {63'h0, bus.bht_update_o.taken}, {63'h0, e_taken});
        chk("count", 64'(bus.count_o), 64'(mq.size()));
        chk("full", {63'h0, bus.full_o}, {63'h0, (mq.size() == DEPTH)});
        chk("drop_cnt", 64'(bus.drop_cnt_o), 64'(m_drop));
    endtask

    task automatic model_update(input logic rv, input logic [63:0] pc, input logic tk,
                                input logic cond, input logic rdy, input logic fl,
                                input logic dbg, input logic rs);
        bit push, pop, coal, was_full;
        if (rs) begin
            mq.delete();
            m_drop = 0;
        end else if (fl) begin
            mq.delete();
        end else begin
            push     = rv && cond && !dbg;
            pop      = (mq.size() > 0) && !dbg && rdy;
            was_full = (mq.size() == DEPTH);
            coal     = 1'b0;
`ifdef BHT_UPD_COALESCE_EN
            coal = push && (mq.size() > 0) && (mq[$].pc == pc) && !(pop && mq.size() == 1);
`endif
            if (coal) mq[$].taken = tk;
            if (pop) void'(mq.pop_front());
            if (push && !coal) begin
                if (!was_full || pop) mq.push_back('{pc: pc, taken: tk});
                else if (m_drop < DROP_MAX) m_drop++;
            end
        end
    endtask

    task automatic step(input logic rv, input logic [63:0] pc, input logic tk,
                        input logic cond, input logic rdy, input logic fl,
                        input logic dbg, input logic rs);
        @(negedge clk);
        bus.resolve_valid_i   = rv;
        bus.resolve_pc_i      = pc;
        bus.resolve_taken_i   = tk;
        bus.resolve_is_cond_i = cond;
        bus.update_ready_i    = rdy;
        bus.flush_i           = fl;
        bus.debug_mode_i      = dbg;
        rst                   = rs;
        #1;
        check_outputs(dbg);
        model_update(rv, pc, tk, cond, rdy, fl, dbg, rs);
        vectors++;
    endtask

    task automatic push(input logic [63:0] pc, input logic tk, input logic rdy);
        step(1'b1, pc, tk, 1'b1, rdy, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 64'h0, 1'b0, 1'b0, rdy, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst                   = 1'b1;
        bus.flush_i           = 1'b0;
        bus.debug_mode_i      = 1'b0;
        bus.resolve_valid_i   = 1'b0;
        bus.resolve_pc_i      = 64'h0;
        bus.resolve_taken_i   = 1'b0;
        bus.resolve_is_cond_i = 1'b0;
        bus.update_ready_i    = 1'b0;

        // reset
        step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);

        // three pushes draining in order
        push(64'h1000, 1'b1, 1'b1);
        push(64'h1004, 1'b0, 1'b1);
        push(64'h1008, 1'b1, 1'b1);
        idle(1'b1);
        idle(1'b1);
        chk("drain_empty", 64'(bus.count_o), 64'd0);

        // non-conditional resolve ignored
        step(1'b1, 64'h1100, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1'b0);

        // six pushes with ready low: two drops
        for (int i = 0; i < 6; i++) push(64'h3000 + 64'(i * 4), i[0], 1'b0);
        idle(1'b0);
        chk("full_after_six", {63'h0, bus.full_o}, 64'd1);
        chk("drop_after_six", 64'(bus.drop_cnt_o), 64'd2);

        // full with push and pop together
        push(64'h3100, 1'b1, 1'b1);
        idle(1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // flush with a simultaneous push
        push(64'h4000, 1'b1, 1'b0);
        push(64'h4004, 1'b0, 1'b0);
        step(1'b1, 64'h4008, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        chk("flush_count", 64'(bus.count_o), 64'd0);

        // debug mode holds entries and ignores pushes
        push(64'h5000, 1'b1, 1'b0);
        push(64'h5004, 1'b0, 1'b0);
        step(1'b1, 64'h5008, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 64'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) idle(1'b1);

        // same-PC push: coalesces only when the macro is defined
        push(64'h2000, 1'b1, 1'b0);
        push(64'h2000, 1'b0, 1'b0);
        idle(1'b0);
`ifdef BHT_UPD_COALESCE_EN
        chk("coalesce_count", 64'(bus.count_o), 64'd1);
`else
        chk("coalesce_count", 64'(bus.count_o), 64'd2);
`endif
        for (int i = 0; i < 3; i++) idle(1'b1);

        // drop counter saturation
        for (int i = 0; i < DEPTH + DROP_MAX + 3; i++) push(64'h6000 + 64'(i * 4), 1'b1, 1'b0);
        idle(1'b0);
        chk("drop_saturate", 64'(bus.drop_cnt_o), 64'(DROP_MAX));

        // reset mid-operation
        step(1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(1'b0);

        // randomized traffic over a small PC set to exercise repeats
        for (int i = 0; i < 600; i++) begin
            logic [63:0] rpc;
            rpc = 64'h7000 + 64'($urandom_range(0, 3) * 4);
            step(($urandom_range(0, 99) < 70), rpc, $urandom_range(0, 1),
                 ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 8),
                 ($urandom_range(0, 199) < 1));
        end
        for (int i = 0; i < 6; i++) idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
